prog_loader: RTL and testbench

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/prog_loader.sv | 190 +++++++++++++++++++
 tb/tb_prog_loader.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// prog_loader: receives a length-prefixed byte image from a host and shifts it,
// word by word, into the JTAG RAM chain, then zero-pads the chain to DEPTH words.
// Optional feature macro: PROG_LOADER_CHKSUM_EN adds a trailing XOR checksum byte (CHK/ERR).
module prog_loader #(
   parameter int DEPTH = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        byte_valid,
   input  logic [7:0]  byte_data,
   output logic        byte_ready,
   output logic        Jen,
   output logic [31:0] Jin,
   output logic        core_rst,
   output logic        done,
   output logic        err,
   output logic [10:0] word_count
);

   // word_count is 11 bits wide, so DEPTH must not exceed 2047
   localparam logic [10:0] DEPTH_W  = 11'(DEPTH);
   localparam logic [15:0] DEPTH_16 = 16'(DEPTH);

   typedef enum logic [3:0] {
      IDLE,
      HDR_HI,
      HDR_LO,
      DATA,
      SHIFT,
      PAD,
`ifdef PROG_LOADER_CHKSUM_EN
      CHK,
`endif
      DONE,
      ERR
   } state_t;

   // where the loader goes once the chain holds DEPTH words
`ifdef PROG_LOADER_CHKSUM_EN
   localparam state_t FINISH = CHK;
`else
   localparam state_t FINISH = DONE;
`endif

   state_t      state, state_d;
   logic [31:0] word_q, word_d;      // word being assembled, big-endian
   logic [1:0]  byte_idx, idx_d;     // byte position within the current word
   logic [7:0]  len_hi, len_hi_d;    // high header byte, held until the low byte arrives
   logic [10:0] len_l, len_d;        // clamped data word count L
   logic [10:0] wc_d;
   logic [10:0] wc_inc;              // saturating word_count + 1
   logic [15:0] hdr_len;
`ifdef PROG_LOADER_CHKSUM_EN
   logic [7:0]  csum, csum_d;        // running XOR of header and data bytes
`endif

   assign hdr_len = {len_hi, byte_data};
   assign wc_inc  = (word_count >= DEPTH_W) ? word_count : word_count + 11'd1;

   // next-state, datapath next values and Moore outputs
   always_comb begin
      state_d    = state;
      word_d     = word_q;
      idx_d      = byte_idx;
      len_hi_d   = len_hi;
      len_d      = len_l;
      wc_d       = word_count;
`ifdef PROG_LOADER_CHKSUM_EN
      csum_d     = csum;
`endif
      byte_ready = 1'b0;
      Jen        = 1'b0;
      Jin        = 32'd0;
      core_rst   = 1'b1;
      done       = 1'b0;
      err        = 1'b0;

      case (state)
         IDLE, DONE, ERR: begin
            if (state == DONE) begin
               done     = 1'b1;
               core_rst = 1'b0;
            end
`ifdef PROG_LOADER_CHKSUM_EN
            if (state == ERR) err = 1'b1;
`endif
            if (start) begin
               state_d = HDR_HI;
               wc_d    = 11'd0;
               idx_d   = 2'd0;
`ifdef PROG_LOADER_CHKSUM_EN
               csum_d  = 8'd0;
`endif
            end
         end

         HDR_HI: begin
            byte_ready = 1'b1;
            if (byte_valid) begin
               len_hi_d = byte_data;
               state_d  = HDR_LO;
`ifdef PROG_LOADER_CHKSUM_EN
               csum_d   = csum ^ byte_data;
`endif
            end
         end

         HDR_LO: begin
            byte_ready = 1'b1;
            if (byte_valid) begin
               // zero or oversize length means "fill the whole chain with data"
               if (hdr_len == 16'd0 || hdr_len > DEPTH_16) len_d = DEPTH_W;
               else                                        len_d = hdr_len[10:0];
               idx_d   = 2'd0;
               state_d = DATA;
`ifdef PROG_LOADER_CHKSUM_EN
               csum_d  = csum ^ byte_data;
`endif
            end
         end

         DATA: begin
            byte_ready = 1'b1;
            if (byte_valid) begin
               word_d = {word_q[23:0], byte_data};
               idx_d  = byte_idx + 2'd1;
               if (byte_idx == 2'd3) state_d = SHIFT;
`ifdef PROG_LOADER_CHKSUM_EN
               csum_d = csum ^ byte_data;
`endif
            end
         end

         SHIFT: begin
            Jen  = 1'b1;
            Jin  = word_q;
            wc_d = wc_inc;
            // wc_inc is the number of words in the chain after this shift
            if (wc_inc < len_l)        state_d = DATA;
            else if (wc_inc < DEPTH_W) state_d = PAD;
            else                       state_d = FINISH;
         end

         PAD: begin
            Jen  = 1'b1;
            wc_d = wc_inc;
            if (wc_inc >= DEPTH_W) state_d = FINISH;
         end

`ifdef PROG_LOADER_CHKSUM_EN
         CHK: begin
            byte_ready = 1'b1;
            if (byte_valid) begin
               if (byte_data == csum) state_d = DONE;
               else                   state_d = ERR;
            end
         end
`endif

         default: state_d = IDLE;
      endcase
   end

   // state and datapath registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         word_q     <= 32'd0;
         byte_idx   <= 2'd0;
         len_hi     <= 8'd0;
         len_l      <= 11'd0;
         word_count <= 11'd0;
`ifdef PROG_LOADER_CHKSUM_EN
         csum       <= 8'd0;
`endif
      end else begin
         state      <= state_d;
         word_q     <= word_d;
         byte_idx   <= idx_d;
         len_hi     <= len_hi_d;
         len_l      <= len_d;
         word_count <= wc_d;
`ifdef PROG_LOADER_CHKSUM_EN
         csum       <= csum_d;
`endif
      end
   end

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: randomized loads against a queue-based model of the chain contents.
// Model: chain image = first L host words followed by DEPTH-L zero words, pad contiguous.
// Honours PROG_LOADER_CHKSUM_EN for the trailing checksum byte.
`timescale 1ns/1ps
module tb_prog_loader;

   localparam int DEPTH = 1024;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        byte_valid;
   logic [7:0]  byte_data;
   logic        byte_ready;
   logic        Jen;
   logic [31:0] Jin;
   logic        core_rst;
   logic        done;
   logic        err;
   logic [10:0] word_count;

   prog_loader #(.DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .byte_valid (byte_valid),
      .byte_data  (byte_data),
      .byte_ready (byte_ready),
      .Jen        (Jen),
      .Jin        (Jin),
      .core_rst   (core_rst),
      .done       (done),
      .err        (err),
      .word_count (word_count)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;
   bit abort    = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
   endtask

   // cycle counter and chain monitor
   int          cyc = 0;
   logic [31:0] shift_q[$];
   int          shift_cyc[$];
   int          viol = 0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (Jen === 1'b1) begin
         shift_q.push_back(Jin);
         shift_cyc.push_back(cyc);
      end
      if (Jen === 1'b0 && Jin !== 32'd0) viol++;
      if (Jen === 1'b1 && byte_ready === 1'b1) viol++;
      if (done === 1'b1 && core_rst !== 1'b0) viol++;
      if (done === 1'b0 && core_rst !== 1'b1) viol++;
      if (word_count > DEPTH) viol++;
`ifndef PROG_LOADER_CHKSUM_EN
      if (err !== 1'b0) viol++;
`endif
   end

   logic [31:0] words[$];
   logic [7:0]  exp_sum;

   function automatic int rgap(input int maxgap);
      return (maxgap == 0) ? 0 : int'($urandom_range(0, maxgap));
   endfunction

   // offer one byte after 'gap' idle cycles; returns just after the transfer edge
   task automatic send_byte(input logic [7:0] b, input int gap, input bit chk_stall);
      int t;
      if (abort) return;
      for (int g = 0; g < gap; g++) begin
         byte_valid = 1'b0;
         byte_data  = 8'($urandom);
         @(negedge clk);
         if (chk_stall) begin
            check("stall_ready", byte_ready, 1);
            check("stall_jen", Jen, 0);
         end
         @(posedge clk); #1;
      end
      byte_valid = 1'b1;
      byte_data  = b;
      t = 0;
      forever begin
         @(negedge clk);
         if (byte_ready) break;
         t++;
         if (t > 3 * DEPTH) begin
            check("ready_timeout", 0, 1);
            abort = 1'b1;
            break;
         end
      end
      @(posedge clk); #1;
      byte_valid = 1'b0;
   endtask

   // start a load and stream header and data; returns the model's L
   task automatic feed(input logic [15:0] len, input int maxgap, input bit poke,
                       input bit stall5, output int L);
      logic [31:0] wv;
      logic [7:0]  by;
      int          g;
      L = (len == 16'd0 || len > DEPTH) ? DEPTH : int'(len);
      while (words.size() < L) words.push_back($urandom);
      shift_q.delete();
      shift_cyc.delete();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check("start_done_clr", done, 0);
      check("start_err_clr", err, 0);
      check("start_wc_clr", word_count, 0);
      check("start_core_rst", core_rst, 1);
      exp_sum = len[15:8] ^ len[7:0];
      send_byte(len[15:8], rgap(maxgap), 1'b0);
      send_byte(len[7:0], rgap(maxgap), 1'b0);
      for (int w = 0; w < L && !abort; w++) begin
         wv = words[w];
         for (int b = 0; b < 4; b++) begin
            if (poke && w == 1 && b == 0) begin
               start = 1'b1;
               repeat (2) @(posedge clk);
               #1;
               start = 1'b0;
            end
            by = wv[31 - 8 * b -: 8];
            g  = (stall5 && w == 0 && b == 2) ? 5 : rgap(maxgap);
            send_byte(by, g, b != 0);
            exp_sum ^= by;
         end
      end
   endtask

   task automatic run_load(input logic [15:0] len, input int maxgap, input bit poke,
                           input bit bad_sum, input bit stall5);
      int L, t, mism, gaps, k0;
      if (abort) return;
      feed(len, maxgap, poke, stall5, L);
`ifdef PROG_LOADER_CHKSUM_EN
      send_byte(bad_sum ? (exp_sum ^ 8'($urandom_range(1, 255))) : exp_sum, rgap(maxgap), 1'b0);
`endif
      if (abort) return;
      t = 0;
      while (!(done || err)) begin
         @(negedge clk);
         t++;
         if (t > 2 * DEPTH + 50) begin
            check("done_timeout", 0, 1);
            abort = 1'b1;
            return;
         end
      end
      @(negedge clk);
      check("done", done, !bad_sum);
      check("err", err, bad_sum);
      check("core_rst_end", core_rst, bad_sum);
      check("wc_final", word_count, DEPTH);
      check("n_shifts", shift_q.size(), DEPTH);
      mism = 0;
      foreach (shift_q[k]) begin
         if (shift_q[k] !== ((k < L) ? words[k] : 32'd0)) mism++;
      end
      check("jin_mismatches", mism, 0);
      gaps = 0;
      k0 = (L < 1) ? 1 : L;
      for (int k = k0; k < shift_cyc.size(); k++)
         if (shift_cyc[k] != shift_cyc[k-1] + 1) gaps++;
      check("pad_gaps", gaps, 0);
      repeat (5) @(negedge clk);
      check("hold_wc", word_count, DEPTH);
      check("hold_shifts", shift_q.size(), DEPTH);
      check("hold_done", done, !bad_sum);
      words.delete();
   endtask

   initial begin
      #5_000_000;
      $display("FAIL global_timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   initial begin
      int L, t, n;
      rst        = 1'b1;
      start      = 1'b0;
      byte_valid = 1'b0;
      byte_data  = 8'd0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_jen", Jen, 0);
      check("rst_jin", Jin, 0);
      check("rst_ready", byte_ready, 0);
      check("rst_done", done, 0);
      check("rst_err", err, 0);
      check("rst_wc", word_count, 0);
      check("rst_core_rst", core_rst, 1);
      rst = 1'b0;

      // two-word program, byte_valid never dropped
      words = '{32'h20010005, 32'h00221820};
      run_load(16'h0002, 0, 1'b0, 1'b0, 1'b0);
      // zero and oversize lengths fill the whole chain with data
      run_load(16'h0000, 0, 1'b0, 1'b0, 1'b0);
      run_load(16'hFFFF, 0, 1'b0, 1'b0, 1'b0);
      run_load(16'(DEPTH + 1), 0, 1'b0, 1'b0, 1'b0);
      // 5-cycle stall between bytes 2 and 3 of the first word
      run_load(16'd3, 0, 1'b0, 1'b0, 1'b1);
      // start pulsed mid-load
      run_load(16'd4, 2, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++)
         run_load(16'($urandom_range(1, 40)), 3, 1'($urandom), 1'b0, 1'b0);
      run_load(16'($urandom_range(41, DEPTH)), 0, 1'b0, 1'b0, 1'b0);

      // reset during padding
      if (!abort) begin
         feed(16'd2, 0, 1'b0, 1'b0, L);
         t = 0;
         while (word_count != 11'd300 && !abort) begin
            @(negedge clk);
            t++;
            if (t > 2 * DEPTH) begin
               check("pad300_timeout", 0, 1);
               abort = 1'b1;
            end
         end
         if (!abort) begin
            rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
            check("midrst_jen", Jen, 0);
            check("midrst_wc", word_count, 0);
            check("midrst_core_rst", core_rst, 1);
            check("midrst_ready", byte_ready, 0);
            check("midrst_done", done, 0);
            n = shift_q.size();
            repeat (20) @(negedge clk);
            check("midrst_no_shift", shift_q.size(), n);
            check("midrst_idle_wc", word_count, 0);
            words.delete();
            run_load(16'($urandom_range(1, 20)), 1, 1'b0, 1'b0, 1'b0);
         end
      end

`ifdef PROG_LOADER_CHKSUM_EN
      words = '{32'h11223344};
      run_load(16'h0001, 0, 1'b0, 1'b0, 1'b0);
      words = '{32'h11223344};
      run_load(16'h0001, 0, 1'b0, 1'b1, 1'b0);
      run_load(16'($urandom_range(1, 20)), 2, 1'b0, 1'b0, 1'b0);
      run_load(16'($urandom_range(1, 20)), 2, 1'b0, 1'b1, 1'b0);
      run_load(16'($urandom_range(1, 20)), 0, 1'b0, 1'b0, 1'b0);
`endif

      check("rule_violations", viol, 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
